// File: rtl/axis_fifo_sync.sv
// axis_fifo_sync: single-clock first-word-fall-through AXI-Stream FIFO with beat and packet occupancy.
module axis_fifo_sync #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DW-1:0]              s_tdata,
  input  logic                       s_tvalid,
  input  logic                       s_tlast,
  output logic                       s_tready,
  output logic [DW-1:0]              m_tdata,
  output logic                       m_tvalid,
  output logic                       m_tlast,
  input  logic                       m_tready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     pkt_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DW:0]   mem [DEPTH];
  logic [CW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic          wr, rd;
  always_comb begin
    wr     = s_tvalid && s_tready;
    rd     = m_tvalid && m_tready;
    wr_nxt = wr ? wr_ptr + CW'(1) : wr_ptr;
    rd_nxt = rd ? rd_ptr + CW'(1) : rd_ptr;
  end
  assign m_tvalid            = wr_ptr != rd_ptr;
  assign {m_tlast, m_tdata}  = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (wr && !rst) mem[wr_ptr[AW-1:0]] <= {s_tlast, s_tdata};
  // ready looks at next-state pointers so a full-state read reopens the input one edge later
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_count <= '0;
      s_tready  <= 1'b0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      count     <= count + CW'(wr) - CW'(rd);
      pkt_count <= pkt_count + CW'(wr && s_tlast) - CW'(rd && m_tlast);
      s_tready  <= !(wr_nxt[AW] != rd_nxt[AW] && wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end
  end
endmodule

// File: tb/tb_axis_fifo_sync.sv
// tb_axis_fifo_sync: vector table, directed corner sequences and random traffic against a queue model.
module tb_axis_fifo_sync;
  localparam int DW = 8, DEPTH = 16;
  logic clk = 0, rst = 1, s_tvalid = 0, s_tlast = 0, m_tready = 0;
  logic [DW-1:0] s_tdata = '0, m_tdata;
  logic s_tready, m_tvalid, m_tlast;
  logic [4:0] count, pkt_count;
  int nvec = 0, nerr = 0;
  logic [8:0] q[$];
  bit ref_ready = 0, acc;
  always #5 clk = ~clk;
  axis_fifo_sync #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .count(count), .pkt_count(pkt_count)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic int pkts();
    int n = 0;
    foreach (q[i]) n += int'(q[i][8]);
    return n;
  endfunction
  // one clock: drive, advance the queue model by the handshake rules, then compare everything
  task automatic step(input bit r, input bit v, input bit l, input bit rd, input logic [7:0] d);
    logic [8:0] h;
    rst = r; s_tvalid = v; s_tlast = l; m_tready = rd; s_tdata = d;
    @(posedge clk);
    acc = !r && v && ref_ready;
    if (r) begin
      q.delete();
      ref_ready = 0;
    end else begin
      if (rd && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back({l, d});
      ref_ready = q.size() < DEPTH;
    end
    #1;
    chk("model s_tready", 32'(s_tready), 32'(ref_ready));
    chk("model m_tvalid", 32'(m_tvalid), 32'(q.size() > 0));
    chk("model count", 32'(count), 32'(q.size()));
    chk("model pkt_count", 32'(pkt_count), 32'(pkts()));
    if (q.size() > 0) begin
      h = q[0];
      chk("model m_tdata", 32'(m_tdata), 32'(h[7:0]));
      chk("model m_tlast", 32'(m_tlast), 32'(h[8]));
    end
  endtask
  typedef struct {
    bit r, v, l, rd;
    logic [7:0] d;
    bit er, ev;
    logic [7:0] ed;
    int ec, ep;
  } vec_t;
  vec_t tv[9];
  initial begin
    bit pend, src, l;
    logic [7:0] d;
    int bi, cnt;
    tv[0] = '{1, 1, 0, 0, 8'hAA, 0, 0, 8'h00, 0, 0};
    tv[1] = '{1, 1, 0, 0, 8'hAA, 0, 0, 8'h00, 0, 0};
    tv[2] = '{1, 1, 0, 0, 8'hAA, 0, 0, 8'h00, 0, 0};
    tv[3] = '{0, 0, 0, 0, 8'hAA, 1, 0, 8'h00, 0, 0};
    tv[4] = '{0, 1, 0, 0, 8'h11, 1, 1, 8'h11, 1, 0};
    tv[5] = '{0, 1, 1, 1, 8'h22, 1, 1, 8'h22, 1, 1};
    tv[6] = '{0, 0, 0, 1, 8'h00, 1, 0, 8'h00, 0, 0};
    tv[7] = '{0, 1, 1, 1, 8'h33, 1, 1, 8'h33, 1, 1};
    tv[8] = '{0, 0, 0, 0, 8'h00, 1, 1, 8'h33, 1, 1};
    foreach (tv[i]) begin
      step(tv[i].r, tv[i].v, tv[i].l, tv[i].rd, tv[i].d);
      chk($sformatf("vec%0d s_tready", i), 32'(s_tready), 32'(tv[i].er));
      chk($sformatf("vec%0d m_tvalid", i), 32'(m_tvalid), 32'(tv[i].ev));
      chk($sformatf("vec%0d count", i), 32'(count), 32'(tv[i].ec));
      chk($sformatf("vec%0d pkt_count", i), 32'(pkt_count), 32'(tv[i].ep));
      if (tv[i].ev) chk($sformatf("vec%0d m_tdata", i), 32'(m_tdata), 32'(tv[i].ed));
    end
    step(0, 0, 0, 1, 8'h00);
    // fill to full with no reads, then drain in order
    for (int i = 0; i < 16; i++) step(0, 1, i == 7 || i == 15, 0, 8'(2 * i));
    chk("fill count", 32'(count), 16);
    chk("fill pkt_count", 32'(pkt_count), 2);
    chk("fill s_tready", 32'(s_tready), 0);
    for (int i = 0; i < 16; i++) begin
      chk("drain m_tdata", 32'(m_tdata), 32'(2 * i));
      chk("drain m_tlast", 32'(m_tlast), 32'(i == 7 || i == 15));
      step(0, 0, 0, 1, 8'h00);
    end
    chk("drain count", 32'(count), 0);
    chk("drain m_tvalid", 32'(m_tvalid), 0);
    // streaming through the wrap: one beat in, one beat out, occupancy pinned at 1
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 0, 1, 8'(3 * (i + 1)));
      chk("stream count", 32'(count), 1);
      chk("stream s_tready", 32'(s_tready), 1);
      chk("stream m_tdata", 32'(m_tdata), 32'(8'(3 * (i + 1))));
    end
    step(0, 0, 0, 1, 8'h00);
    // full with a simultaneous read: write held off one cycle
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 8'(i + 8'h40));
    step(0, 1, 1, 1, 8'h77);
    chk("fullrd count", 32'(count), 15);
    chk("fullrd s_tready", 32'(s_tready), 1);
    step(0, 1, 1, 0, 8'h77);
    chk("fullrd retry count", 32'(count), 16);
    chk("fullrd retry pkt_count", 32'(pkt_count), 1);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 1, 8'h00);
    chk("fullrd empty", 32'(m_tvalid), 0);
    // two sources in 20-beat bursts, random valid and back-pressure
    pend = 0; src = 0; bi = 0; cnt = 0; l = 0; d = '0;
    for (int c = 0; c < 600; c++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1;
        d = {src, 7'(cnt)};
        l = bi == 19 || $urandom_range(0, 7) == 0;
      end
      step(0, pend, l, $urandom_range(0, 1) == 1, d);
      if (acc) begin
        pend = 0;
        cnt++;
        bi = bi == 19 ? 0 : bi + 1;
        if (bi == 0) src = !src;
      end
    end
    for (int i = 0; i < 17; i++) step(0, 0, 0, 1, 8'h00);
    // reset in the middle of a packet discards everything
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'(i + 8'h90));
    step(1, 0, 0, 0, 8'h00);
    chk("midrst count", 32'(count), 0);
    chk("midrst pkt_count", 32'(pkt_count), 0);
    chk("midrst m_tvalid", 32'(m_tvalid), 0);
    step(0, 0, 0, 0, 8'h00);
    step(0, 1, 1, 0, 8'h55);
    chk("midrst first m_tvalid", 32'(m_tvalid), 1);
    chk("midrst first m_tdata", 32'(m_tdata), 32'h55);
    chk("midrst first count", 32'(count), 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
